// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
//   bcd_digit_t   : one packed-BCD digit
//   state_t       : controller states (IDLE, RUN, DONE)
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   nines_comp()  : nines complement of a digit (wraps for non-BCD input)
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  function automatic bcd_digit_t nines_comp(bcd_digit_t d);
    return BCD_MAX_DIGIT - d;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry correction.
// Ports:
//   a, b : BCD digits (non-BCD values are processed by the same formula)
//   cin  : carry into this digit
//   s    : corrected BCD sum digit
//   cout : decimal carry out (digit sum exceeded 9)
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t s,
  output logic       cout
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (t > {1'b0, BCD_MAX_DIGIT}) begin
      // Adding 6 skips the six unused codes; the bit-4 overflow is the carry.
      s    = t[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction is a + nines_comp(b) + ~borrow_in (ten's complement).
// Optional feature macro: BCD_INVALID_DETECT_EN (flags non-BCD operand digits on err).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, op, cin)
//   op                   : 0 = add, 1 = subtract
//   cin                  : add carry-in / subtract borrow-in
//   out_valid / out_ready: result handshake (s, cout, err)
//   cout                 : add carry-out / subtract 1 = no borrow
//   err                  : non-BCD digit seen (constant 0 without the macro)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | processing one digit per cycle
// DONE  | result held until out_ready
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter  int N_DIGITS = 4,
  localparam int W        = 4 * N_DIGITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         err
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, s_q;
  logic           op_q, carry_q, cout_q;
  logic [IW-1:0]  idx_q;
  logic           last_digit;

  bcd_digit_t     dig_a, dig_b, dig_s;
  logic           dig_cout;
  logic [W-1:0]   s_shift;

  assign last_digit = (idx_q == IW'(N_DIGITS - 1));
  assign dig_a      = a_q[3:0];
  assign dig_b      = op_q ? nines_comp(b_q[3:0]) : b_q[3:0];

  bcd_digit_adder u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // New digit enters at the top; after N shifts digit 0 lands in [3:0].
  assign s_shift = (s_q >> 4) | (W'(dig_s) << (W - 4));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= op;
          carry_q <= cin ^ op;   // subtract uses the inverted borrow as carry-in
          idx_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          s_q     <= s_shift;
          carry_q <= dig_cout;
          idx_q   <= idx_q + IW'(1);
          if (last_digit) cout_q <= dig_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_INVALID_DETECT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      err_q <= 1'b0;
    end else if (state_q == RUN) begin
      err_q <= err_q | (dig_a > BCD_MAX_DIGIT) | (b_q[3:0] > BCD_MAX_DIGIT);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (N_DIGITS=4): decimal-arithmetic
// reference model, directed literal vectors, backpressure, reset-in-RUN and
// randomized operations.
module tb_bcd_addsub_serial;

  localparam int N   = 4;
  localparam int W   = 4 * N;
  localparam int MOD = 10 ** N;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, op, cin, out_valid, out_ready, cout, err;
  logic [W-1:0] a, b, s;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_s;
  logic         exp_cout, exp_err, exp_s_known, expect_active;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.N_DIGITS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .err       (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_nonbcd(input logic [W-1:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < N; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Decimal reference: add is plain sum mod 10^N, subtract is difference
  // wrapped into [0, 10^N) with cout = "no borrow".
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                       input logic tcin, output logic [W-1:0] rs, output logic rc);
    int r;
    if (!top) begin
      r  = bcd2int(ta) + bcd2int(tb) + int'(tcin);
      rc = (r >= MOD);
      rs = int2bcd(r % MOD);
    end else begin
      r  = bcd2int(ta) - bcd2int(tb) - int'(tcin);
      rc = (r >= 0);
      if (r < 0) r += MOD;
      rs = int2bcd(r);
    end
  endtask

  // Output compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!expect_active) begin
        chk("spurious_out_valid", out_valid, 1'b0);
      end else begin
        if (exp_s_known) chk("s_model", s, exp_s);
        chk("cout_model", cout, exp_cout);
        chk("err_model", err, exp_err);
        chk("in_ready_in_done", in_ready, 1'b0);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                       input logic tcin, input int hold, input logic early_ready,
                       input logic use_lit, input logic [W-1:0] lit_s, input logic lit_c);
    int cyc;
    logic nb;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("in_ready_before_op", in_ready, 1'b1);
    a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1; out_ready = early_ready;
    nb = has_nonbcd(ta) | has_nonbcd(tb);
    model(ta, tb, top, tcin, exp_s, exp_cout);
    exp_s_known = !nb;
`ifdef BCD_INVALID_DETECT_EN
    exp_err = nb;
`else
    exp_err = 1'b0;
`endif
    @(posedge clk); #1;
    expect_active = 1'b1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 1'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, N);
    if (use_lit) begin
      chk("s_literal", s, lit_s);
      chk("cout_literal", cout, lit_c);
    end
    if (!early_ready) begin
      in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_in_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    expect_active = 1'b0;
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1'b1);
    chk("out_valid_after_hs", out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 1'b0; cin = 1'b0;
    expect_active = 1'b0; exp_s = '0; exp_cout = 1'b0; exp_err = 1'b0; exp_s_known = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_s", s, '0);
    chk("reset_cout", cout, 1'b0);
    chk("reset_err", err, 1'b0);

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h6912, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 1'b1, 16'h0000, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 1'b1, 16'h0001, 1'b0);
    do_op(16'h0500, 16'h0123, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'h0377, 1'b1);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0, 0, 1'b1, 1'b1, 16'h9999, 1'b0);
    do_op(16'h0100, 16'h0099, 1'b1, 1'b1, 0, 1'b0, 1'b1, 16'h0000, 1'b1);
    // backpressure with new operands offered while DONE
    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 5, 1'b0, 1'b1, 16'h6912, 1'b0);

    // reset in the middle of RUN, after digit 1
    a = 16'h1234; b = 16'h5678; op = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrun_reset_out_valid", out_valid, 1'b0);
    chk("midrun_reset_in_ready", in_ready, 1'b1);
    chk("midrun_reset_s", s, '0);
    chk("midrun_reset_cout", cout, 1'b0);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0003, 1'b0);

`ifdef BCD_INVALID_DETECT_EN
    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0);
    do_op(16'h0042, 16'h0017, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0059, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = int2bcd(int'($urandom_range(0, MOD - 1)));
      rb = int2bcd(int'($urandom_range(0, MOD - 1)));
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), 1'b0, '0, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
